// File: rtl/prev_frame_buffer_pkg.sv
// Shared constants, the RGB444 storage word and colour helpers for prev_frame_buffer.
package prev_frame_buffer_pkg;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int DEC    = 4;
  localparam int BLK_W  = WIDTH / DEC;
  localparam int BLK_H  = HEIGHT / DEC;
  localparam int ADDR_W = $clog2(BLK_W * BLK_H);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicating the nibble maps 0x0..0xF evenly onto 0x00..0xFF.
  function automatic logic [7:0] expand(input logic [3:0] n);
    return {n, n};
  endfunction

endpackage

// File: rtl/prev_frame_buffer_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on collisions.
module dpram_rd_first #(
  parameter int DEPTH  = 19200,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports sample the array before the update lands, giving old data on a same-address hit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prev_frame_buffer.sv
// Stores a decimated RGB444 copy of each frame and re-emits every pixel with its previous-frame block value.
module prev_frame_buffer #(
  parameter int WIDTH  = prev_frame_buffer_pkg::WIDTH,
  parameter int HEIGHT = prev_frame_buffer_pkg::HEIGHT,
  parameter int DEC    = prev_frame_buffer_pkg::DEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [9:0] in_x,
  input  logic [9:0] in_y,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic [7:0] cur_r,
  output logic [7:0] cur_g,
  output logic [7:0] cur_b,
  output logic [7:0] prev_r,
  output logic [7:0] prev_g,
  output logic [7:0] prev_b,
  output logic       frame_start,
  output logic       prev_ok
);
  import prev_frame_buffer_pkg::*;

  localparam int DEC_SH    = $clog2(DEC);
  localparam int BLK_COLS  = WIDTH / DEC;
  localparam int RAM_DEPTH = BLK_COLS * (HEIGHT / DEC);
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [9:0] X_END = 10'(WIDTH - 1);
  localparam logic [9:0] Y_END = 10'(HEIGHT - 1);

  logic              accept;
  logic              blk_last;
  logic              frame_last;
  logic [RAM_AW-1:0] blk_addr;
  rgb444_t           in_q;
  logic              unused_low_bits;

  logic              s1_valid;
  logic              s1_we;
  logic [RAM_AW-1:0] s1_addr;
  logic [9:0]        s1_x;
  logic [9:0]        s1_y;
  rgb444_t           s1_q;

  logic              s2_valid;
  logic              s2_fs;
  logic              s2_loaded;
  logic [9:0]        s2_x;
  logic [9:0]        s2_y;
  rgb444_t           s2_q;
  rgb444_t           ram_q;

  assign accept     = in_valid && (in_x <= X_END) && (in_y <= Y_END);
  assign blk_last   = (&in_x[DEC_SH-1:0]) && (&in_y[DEC_SH-1:0]);
  assign frame_last = (in_x == X_END) && (in_y == Y_END);
  assign blk_addr   = RAM_AW'((32'(in_y) >> DEC_SH) * BLK_COLS + (32'(in_x) >> DEC_SH));
  assign in_q       = '{r: in_r[7:4], g: in_g[7:4], b: in_b[7:4]};
  assign unused_low_bits = ^{in_r[3:0], in_g[3:0], in_b[3:0]};

  // Stage 1: only the last pixel of a block commits it, so earlier pixels see last frame's value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_addr  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept;
      s1_we    <= accept && blk_last;
      if (accept) begin
        s1_addr <= blk_addr;
        s1_x    <= in_x;
        s1_y    <= in_y;
        s1_q    <= in_q;
      end
    end
  end

  dpram_rd_first #(
    .DEPTH (RAM_DEPTH),
    .DATA_W($bits(rgb444_t)),
    .ADDR_W(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (s1_we),
    .waddr(s1_addr),
    .wdata(s1_q),
    .re   (s1_valid),
    .raddr(s1_addr),
    .rdata(ram_q)
  );

  // Stage 2 runs alongside the RAM's own read register; s2_loaded hides stale RAM output after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_fs     <= 1'b0;
      s2_loaded <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      s2_q      <= '0;
      prev_ok   <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_fs     <= s1_valid && (s1_x == 10'd0) && (s1_y == 10'd0);
      s2_loaded <= s2_loaded || s1_valid;
      if (s1_valid) begin
        s2_x <= s1_x;
        s2_y <= s1_y;
        s2_q <= s1_q;
      end
      if (accept && blk_last && frame_last) begin
        prev_ok <= 1'b1;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign frame_start = s2_fs;
  assign out_x       = s2_x;
  assign out_y       = s2_y;
  assign cur_r       = expand(s2_q.r);
  assign cur_g       = expand(s2_q.g);
  assign cur_b       = expand(s2_q.b);
  assign prev_r      = s2_loaded ? expand(ram_q.r) : 8'h00;
  assign prev_g      = s2_loaded ? expand(ram_q.g) : 8'h00;
  assign prev_b      = s2_loaded ? expand(ram_q.b) : 8'h00;

endmodule

// File: tb/tb_prev_frame_buffer.sv
// Scoreboard bench for prev_frame_buffer on a reduced 16x8 frame with 4x4 blocks.
module tb_prev_frame_buffer;

  localparam int TW    = 16;
  localparam int TH    = 8;
  localparam int TD    = 4;
  localparam int TBC   = TW / TD;
  localparam int TDEP  = TBC * (TH / TD);
  localparam int TPIX  = TW * TH;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [9:0] in_x;
  logic [9:0] in_y;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       out_valid;
  logic [9:0] out_x;
  logic [9:0] out_y;
  logic [7:0] cur_r;
  logic [7:0] cur_g;
  logic [7:0] cur_b;
  logic [7:0] prev_r;
  logic [7:0] prev_g;
  logic [7:0] prev_b;
  logic       frame_start;
  logic       prev_ok;

  typedef struct {
    int         due;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] cr;
    logic [7:0] cg;
    logic [7:0] cb;
    logic [7:0] pr;
    logic [7:0] pg;
    logic [7:0] pb;
    bit         known;
    bit         fs;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] mmem [TDEP];
  bit          mknown [TDEP];
  bit          ok_set;
  int          ok_at;
  int          cyc;
  int          n_checks;
  int          n_pass;
  bit          mon_en;

  prev_frame_buffer #(.WIDTH(TW), .HEIGHT(TH), .DEC(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_r       (in_r),
    .in_g       (in_g),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .cur_r      (cur_r),
    .cur_g      (cur_g),
    .cur_b      (cur_b),
    .prev_r     (prev_r),
    .prev_g     (prev_g),
    .prev_b     (prev_b),
    .frame_start(frame_start),
    .prev_ok    (prev_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] q8(input logic [3:0] n);
    return {n, n};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic applyStimulus(input bit v, input int x, input int y,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    int   a;
    @(posedge clk);
    #1;
    in_valid = v;
    in_x     = 10'(x);
    in_y     = 10'(y);
    in_r     = r;
    in_g     = g;
    in_b     = b;
    if (v && x < TW && y < TH) begin
      a       = (y / TD) * TBC + x / TD;
      e.due   = cyc + 2;
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.cr    = q8(r[7:4]);
      e.cg    = q8(g[7:4]);
      e.cb    = q8(b[7:4]);
      e.known = mknown[a];
      e.pr    = q8(mmem[a][11:8]);
      e.pg    = q8(mmem[a][7:4]);
      e.pb    = q8(mmem[a][3:0]);
      e.fs    = (x == 0) && (y == 0);
      if ((x % TD == TD - 1) && (y % TD == TD - 1)) begin
        mmem[a]   = {r[7:4], g[7:4], b[7:4]};
        mknown[a] = 1'b1;
      end
      if (x == TW - 1 && y == TH - 1 && !ok_set) begin
        ok_set = 1'b1;
        ok_at  = cyc + 1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic runFrame(input int first, input int last, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b, input bit square);
    for (int i = first; i <= last; i++) begin
      if (square && (i % TW) < TD && (i / TW) < TD)
        applyStimulus(1'b1, i % TW, i / TW, 8'hFF, 8'hFF, 8'hFF);
      else
        applyStimulus(1'b1, i % TW, i / TW, r, g, b);
    end
  endtask

  // RAM contents survive reset but in-flight writes may be lost, so the model forgets everything.
  task automatic doReset(input bit busy);
    @(posedge clk);
    #3;
    if (busy) checkOutput("pre_reset_valid", out_valid, 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    ok_set = 1'b0;
    for (int i = 0; i < TDEP; i++) mknown[i] = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_frame_start", frame_start, 0);
    checkOutput("rst_prev_ok", prev_ok, 0);
    checkOutput("rst_out_x", out_x, 0);
    checkOutput("rst_out_y", out_y, 0);
    checkOutput("rst_cur", {cur_r, cur_g, cur_b}, 0);
    checkOutput("rst_prev", {prev_r, prev_g, prev_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      checkOutput("prev_ok", prev_ok, (ok_set && cyc >= ok_at) ? 1 : 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_valid", out_valid, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", cyc, e.due);
          checkOutput("out_xy", {out_x, out_y}, {e.x, e.y});
          checkOutput("cur_rgb", {cur_r, cur_g, cur_b}, {e.cr, e.cg, e.cb});
          checkOutput("frame_start", frame_start, e.fs);
          if (e.known) checkOutput("prev_rgb", {prev_r, prev_g, prev_b}, {e.pr, e.pg, e.pb});
        end
      end else begin
        checkOutput("frame_start_idle", frame_start, 0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          checkOutput("missing_valid", out_valid, 1);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    ok_set   = 1'b0;
    ok_at    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_r     = '0;
    in_g     = '0;
    in_b     = '0;
    for (int i = 0; i < TDEP; i++) mmem[i] = '0;
    doReset(1'b0);
    mon_en = 1'b1;

    // Isolated pulses with a gap: latency 2 and a single frame_start.
    idle(3);
    applyStimulus(1'b1, 0, 0, 8'h12, 8'h34, 8'h56);
    applyStimulus(1'b1, 1, 0, 8'h9A, 8'hBC, 8'hDE);
    idle(3);
    applyStimulus(1'b1, 2, 0, 8'hF1, 8'h0E, 8'h7C);
    idle(4);

    runFrame(0, TPIX - 1, 8'h37, 8'h8C, 8'hF0, 1'b0);
    runFrame(0, TPIX - 1, 8'h37, 8'h8C, 8'hF0, 1'b0);

    runFrame(0, TPIX - 1, 8'h00, 8'h00, 8'h00, 1'b0);
    runFrame(0, TPIX - 1, 8'h00, 8'h00, 8'h00, 1'b1);
    runFrame(0, TPIX - 1, 8'h00, 8'h00, 8'h00, 1'b0);
    idle(3);

    // Out-of-range pixels that would alias onto block 0 if they were not rejected.
    applyStimulus(1'b1, TW, 5, 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(1'b1, TW + 3, 7, 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(1'b1, 3, TH + 3, 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(1'b1, TW - 4, 4, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 0, 0, 8'h00, 8'h00, 8'h00);
    idle(4);

    applyStimulus(1'b1, 3, 3, 8'hA5, 8'h5A, 8'h3C);
    idle(3);
    applyStimulus(1'b1, 3, 3, 8'h61, 8'hE2, 8'h97);
    idle(4);

    runFrame(0, 5 * TW + 9, 8'h2B, 8'hC4, 8'h6D, 1'b0);
    doReset(1'b1);
    runFrame(5 * TW + 10, TPIX - 1, 8'h2B, 8'hC4, 8'h6D, 1'b0);
    idle(2);
    runFrame(0, TPIX - 1, 8'h2B, 8'hC4, 8'h6D, 1'b0);
    idle(6);

    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
